// File: rtl/vram_scanout_reader_if.sv
// VRAM read port plus pixel output stream of the scanout reader.
// Ports: vram_addr/vram_data (registered read, 1-cycle latency); pix/pix_valid/pix_ready
//        stream with x/y position and sof/eol markers. Optional macro: VRAM_SCANOUT_PIXDBL_EN.
interface vram_scanout_reader_if #(
    parameter int ADDR_W     = 13,
    parameter int LINE_BYTES = 64,
    parameter int LINES      = 128
) ();
`ifdef VRAM_SCANOUT_PIXDBL_EN
    localparam int PH_W = 2;
`else
    localparam int PH_W = 1;
`endif
    localparam int X_W = $clog2(LINE_BYTES << PH_W);
    localparam int Y_W = $clog2(LINES);

    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_data;
    logic [3:0]        pix;
    logic              pix_valid;
    logic              pix_ready;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic              sof;
    logic              eol;

    modport master (
        output vram_addr, pix, pix_valid, x, y, sof, eol,
        input  vram_data, pix_ready
    );

    modport slave (
        input  vram_addr, pix, pix_valid, x, y, sof, eol,
        output vram_data, pix_ready
    );
endinterface

// File: rtl/vram_scanout_reader.sv
// Walks a frame of packed 4bpp VRAM bytes and streams pixel indices (low nibble first).
// Latency: first pixel valid 3 cycles after an accepted start; 1 pixel/clock sustained.
// Backpressure: 2-byte buffer, reads throttled by credit; outputs hold while !pix_ready.
// Ports: clk, rst (async active-high), start/abort/base control, busy/done status,
//        bus (master modport: VRAM read port + pixel stream).
// Optional macro VRAM_SCANOUT_PIXDBL_EN: each nibble emitted twice (horizontal doubling).
module vram_scanout_reader #(
    parameter int ADDR_W     = 13,
    parameter int LINE_BYTES = 64,
    parameter int LINES      = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base,
    output logic              busy,
    output logic              done,
    vram_scanout_reader_if.master bus
);
`ifdef VRAM_SCANOUT_PIXDBL_EN
    localparam int PH_W = 2;   // four transfers per byte
`else
    localparam int PH_W = 1;   // two transfers per byte
`endif
    localparam int PPL   = LINE_BYTES << PH_W;
    localparam int X_W   = $clog2(PPL);
    localparam int Y_W   = $clog2(LINES);
    localparam int TOTAL = LINE_BYTES * LINES;
    localparam int RC_W  = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t            state, state_nxt;
    logic              issue;
    logic [RC_W-1:0]   rd_cnt;
    logic              addr_vld;   // vram_addr holds a read this cycle
    logic              data_vld;   // vram_data carries our read this cycle
    logic [7:0]        buf_q [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        cnt_q;
    logic [PH_W-1:0]   phase_q;
    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic [7:0]        head;
    logic              xfer, pop, push, last_pix, x_end, y_end;
    logic [2:0]        occ;

    assign head     = buf_q[rd_ptr];
    assign x_end    = (x_q == X_W'(PPL - 1));
    assign y_end    = (y_q == Y_W'(LINES - 1));
    assign xfer     = bus.pix_valid && bus.pix_ready;
    assign pop      = xfer && (phase_q == '1);
    assign push     = data_vld;
    assign last_pix = xfer && x_end && y_end;

    // Bytes held or in flight once this cycle's pop retires; counting the pop
    // lets a new read launch early enough to avoid a bubble at 1 pixel/clock.
    assign occ = {1'b0, cnt_q} + {2'b0, addr_vld} + {2'b0, data_vld} - {2'b0, pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    issue     = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (occ < 3'd2) begin
                    issue = 1'b1;
                    if (rd_cnt == RC_W'(TOTAL - 1)) state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_pix) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
            issue     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.vram_addr <= '0;
            rd_cnt        <= '0;
            addr_vld      <= 1'b0;
            data_vld      <= 1'b0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            cnt_q         <= 2'd0;
            phase_q       <= '0;
            x_q           <= '0;
            y_q           <= '0;
            done          <= 1'b0;
        end else if (abort) begin
            // In-flight read data is dropped by clearing its qualifiers.
            addr_vld <= 1'b0;
            data_vld <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            cnt_q    <= 2'd0;
            phase_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            done     <= 1'b0;
        end else begin
            done     <= last_pix;
            addr_vld <= issue;
            data_vld <= addr_vld;
            if (issue) begin
                if (state == S_IDLE) begin
                    bus.vram_addr <= base;
                    rd_cnt        <= RC_W'(1);
                end else begin
                    bus.vram_addr <= bus.vram_addr + 1'b1;
                    rd_cnt        <= rd_cnt + 1'b1;
                end
            end
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
            if (xfer) begin
                phase_q <= phase_q + 1'b1;
                if (x_end) begin
                    x_q <= '0;
                    y_q <= y_end ? '0 : y_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (push) buf_q[wr_ptr] <= bus.vram_data;
    end

    assign busy          = (state != S_IDLE);
    assign bus.pix_valid = (cnt_q != 2'd0);
    assign bus.pix       = !bus.pix_valid ? 4'd0 :
                           (phase_q[PH_W-1] ? head[7:4] : head[3:0]);
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.sof       = bus.pix_valid && (x_q == '0) && (y_q == '0);
    assign bus.eol       = bus.pix_valid && x_end;
endmodule

// File: tb/tb_vram_scanout_reader.sv
// Bench for vram_scanout_reader: VRAM behavioural memory, random backpressure, and a
// reference computing each pixel, position and marker directly from its transfer index.
module tb_vram_scanout_reader;
    localparam int ADDR_W     = 13;
    localparam int LINE_BYTES = 64;
    localparam int LINES      = 128;
`ifdef VRAM_SCANOUT_PIXDBL_EN
    localparam int PH_W  = 2;
    localparam int RDY_B = 75;
`else
    localparam int PH_W  = 1;
    localparam int RDY_B = 50;
`endif
    localparam int PPL  = LINE_BYTES << PH_W;
    localparam int NPIX = PPL * LINES;

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base  = '0;
    logic              busy, done;

    vram_scanout_reader_if #(.ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .LINES(LINES)) bus ();

    vram_scanout_reader #(.ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .LINES(LINES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .base  (base),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) bus.vram_data <= mem[bus.vram_addr];

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] first4 [4];
    int         f_k, f_n;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [3:0] p, input int xx, input int yy,
                                         input logic s, input logic e);
        return {p, 4'd0, 8'(xx), 8'(yy), 6'd0, s, e};
    endfunction

    // Transfer k of a frame: byte k/(pixels per byte), nibble chosen by the
    // pixel-within-byte, position by raster order.
    function automatic logic [31:0] exp_at(input int k, input logic [ADDR_W-1:0] b);
        logic [ADDR_W-1:0] a;
        logic [7:0]        by;
        logic [3:0]        p;
        int                xx;
        a  = b + ADDR_W'(k >> PH_W);
        by = mem[a];
        p  = (((k >> (PH_W - 1)) & 1) != 0) ? by[7:4] : by[3:0];
        xx = k % PPL;
        return pack(p, xx, (k / PPL) % LINES, k == 0, xx == PPL - 1);
    endfunction

    function automatic logic [63:0] all_outs();
        return {27'd0, bus.vram_addr, bus.pix_valid, bus.pix, 8'(bus.x), 8'(bus.y),
                bus.sof, bus.eol, busy, done};
    endfunction

    task automatic run_frame(input logic [ADDR_W-1:0] b, input int rdy_pct,
                             input int start_again_n, input int stop_n);
        int k = 0;
        int n = 0;
        bit last_prev = 1'b0;
        bit prev_stall = 1'b0;
        bit fin = 1'b0;
        base          = b;
        start         = 1'b1;
        bus.pix_ready = ($urandom_range(99) < rdy_pct);
        while (!fin && n < 4 * NPIX + 100) begin
            @(negedge clk);
            n++;
            start         = (n == start_again_n);
            bus.pix_ready = ($urandom_range(99) < rdy_pct);
            check("done", 64'(done), 64'(last_prev));
            check("busy", 64'(busy), 64'(!last_prev));
            if (prev_stall) check("hold_valid", 64'(bus.pix_valid), 64'd1);
            last_prev = 1'b0;
            if (bus.pix_valid) begin
                check("pixel", 64'(pack(bus.pix, int'(bus.x), int'(bus.y), bus.sof, bus.eol)),
                      64'(exp_at(k, b)));
                if (k < 4) first4[k] = bus.pix;
                if (bus.pix_ready) begin
                    last_prev = (k == NPIX - 1);
                    k++;
                end
            end
            prev_stall = bus.pix_valid && !bus.pix_ready;
            if (done || (stop_n > 0 && n == stop_n)) fin = 1'b1;
        end
        start = 1'b0;
        f_k   = k;
        f_n   = n;
        if (!fin) check("frame_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int  k;
        bit  hit;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        bus.pix_ready = 1'b0;

        #12;
        check("reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full frame, downstream always ready.
        run_frame('0, 100, 0, 0);
        check("lenA", 64'(f_n), 64'(NPIX + 3));
        check("cntA", 64'(f_k), 64'(NPIX));
`ifdef VRAM_SCANOUT_PIXDBL_EN
        check("firstA", {48'd0, first4[0], first4[1], first4[2], first4[3]}, 64'h0000);
`else
        check("firstA", {48'd0, first4[0], first4[1], first4[2], first4[3]}, 64'h0010);
`endif
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        // Abort while pixel 300 is presented.
        base          = '0;
        start         = 1'b1;
        bus.pix_ready = 1'b1;
        k   = 0;
        hit = 1'b0;
        for (int c = 0; c < 4000 && !hit; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus.pix_valid) begin
                if (k == 300) begin
                    abort = 1'b1;
                    hit   = 1'b1;
                end else begin
                    k++;
                end
            end
        end
        if (!hit) check("abort_timeout", 64'd0, 64'd1);
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", 64'(bus.pix_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_xy", {48'd0, 8'(bus.x), 8'(bus.y)}, 64'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("abort_no_done", 64'(done), 64'd0);
        end
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_beats_start", 64'(busy), 64'd0);
        @(negedge clk);

        // Address wrap with random backpressure over a full frame.
        mem[(1 << ADDR_W) - 1] = 8'hA5;
        mem[0]                 = 8'h3C;
        run_frame(ADDR_W'((1 << ADDR_W) - 1), RDY_B, 0, 0);
        check("cntB", 64'(f_k), 64'(NPIX));
`ifdef VRAM_SCANOUT_PIXDBL_EN
        check("firstB", {48'd0, first4[0], first4[1], first4[2], first4[3]}, 64'h55AA);
`else
        check("firstB", {48'd0, first4[0], first4[1], first4[2], first4[3]}, 64'h5AC3);
`endif
        @(negedge clk);

        // Mid-frame start pulse is ignored; then asynchronous reset mid-frame.
        mem[0] = 8'h21;
        run_frame('0, 70, 500, 1000);
`ifdef VRAM_SCANOUT_PIXDBL_EN
        check("firstC", {48'd0, first4[0], first4[1], first4[2], first4[3]}, 64'h1122);
`else
        check("firstC", {48'd0, first4[0], first4[1], first4[2], first4[3]}, 64'h1210);
`endif
        check("busy_before_rst", 64'(busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", all_outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
